instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, buffer depth and entry layout for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;
    localparam int FETCH_DEPTH   = 2;
    localparam int FETCH_CNT_W   = $clog2(FETCH_DEPTH + 1);

    // A buffered fetch result: the address travels with its instruction word.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO holding returned instructions; entry 0 is always the head
// so the output is a plain register and stays put while decode stalls.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_ADDR_W + FETCH_INSTR_W
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [FETCH_CNT_W-1:0] o_count,
    output logic [DATA_W-1:0]      o_head
);

    localparam logic [FETCH_CNT_W-1:0] LP_ONE  = FETCH_CNT_W'(1);
    localparam logic [FETCH_CNT_W-1:0] LP_FULL = FETCH_CNT_W'(FETCH_DEPTH);

    logic [DATA_W-1:0]      r_mem0;
    logic [DATA_W-1:0]      r_mem1;
    logic [FETCH_CNT_W-1:0] r_count;
    logic                   w_pop;
    logic                   w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != LP_FULL) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem1 <= i_data;
                    end
                    r_count <= r_count + LP_ONE;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - LP_ONE;
                end
                2'b11: begin
                    if (r_count == LP_ONE) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues single-cycle-latency memory reads for accepted
// PCs and buffers the returned words for decode, with a credit-based ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               flush,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int                     LP_ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [FETCH_CNT_W:0]   LP_DEPTH   = (FETCH_CNT_W + 1)'(FETCH_DEPTH);

    logic                    r_inflight;
    logic [ADDR_W-1:0]       r_inflight_pc;
    logic                    w_acc;
    logic                    w_pop;
    logic [FETCH_CNT_W-1:0]  w_count;
    logic [FETCH_CNT_W:0]    w_pending;
    logic [FETCH_CNT_W:0]    w_outstanding;
    logic [LP_ENTRY_W-1:0]   w_head;

    assign w_pop = instr_valid & instr_ready;

    // Credit counts buffered plus in-flight work, minus what decode takes this
    // cycle, so a draining buffer keeps the pipe full at one fetch per cycle.
    assign w_outstanding = {1'b0, w_count} + {{FETCH_CNT_W{1'b0}}, r_inflight};
    assign w_pending     = w_outstanding - {{FETCH_CNT_W{1'b0}}, w_pop};
    assign pc_ready      = reset_n & !flush & (w_pending < LP_DEPTH);

    assign w_acc    = pc_valid & pc_ready;
    assign mem_en   = w_acc;
    assign mem_addr = pc_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_acc & !flush;
            if (w_acc) begin
                r_inflight_pc <= pc_in;
            end
        end
    end

    fetch_fifo #(
        .DATA_W (LP_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_pc, mem_rdata}),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign instr_valid = (w_count != '0);
    assign instr_pc    = w_head[LP_ENTRY_W-1:INSTR_W];
    assign instr       = w_head[INSTR_W-1:0];

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        w_outstanding <= LP_DEPTH);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory, a cycle-accurate scoreboard of
// outstanding fetches, and directed plus random handshake sequences.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [7:0]  pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fetch_entry_t expQ[$];
    int           cycQ[$];
    fetch_entry_t newEntry;
    logic         expValid;
    logic         expPop;
    logic         expReady;

    instr_fetch #(
        .ADDR_W  (8),
        .INSTR_W (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory: word content is 0x1000 plus its address.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= 16'h1000 + {8'h00, mem_addr};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic r, input logic f);
        @(posedge clk);
        #1;
        pc_valid    = v;
        pc_in       = a;
        instr_ready = r;
        flush       = f;
    endtask

    // An entry accepted in cycle N is presentable from cycle N+2 onward; the
    // queue length is the number of buffered plus in-flight fetches.
    always @(negedge clk) begin
        if (!reset_n) begin
            expQ.delete();
            cycQ.delete();
        end else begin
            expValid = 1'b0;
            if (expQ.size() != 0) begin
                expValid = (cycQ[0] + 2 <= cyc);
            end
            expPop   = expValid & instr_ready;
            expReady = !flush && ((expQ.size() - (expPop ? 1 : 0)) < 2);
            checkOutput("pc_ready", 32'(pc_ready), 32'(expReady));
            checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
            checkOutput("mem_en", 32'(mem_en), 32'(pc_valid & expReady));
            if (pc_valid & expReady) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(pc_in));
            end
            if (expValid) begin
                checkOutput("instr", 32'(instr), 32'(expQ[0].instr));
                checkOutput("instr_pc", 32'(instr_pc), 32'(expQ[0].pc));
            end
            if (expPop) begin
                void'(expQ.pop_front());
                void'(cycQ.pop_front());
            end
            if (flush) begin
                expQ.delete();
                cycQ.delete();
            end else if (pc_valid & expReady) begin
                newEntry.pc    = pc_in;
                newEntry.instr = 16'h1000 + {8'h00, pc_in};
                expQ.push_back(newEntry);
                cycQ.push_back(cyc);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        pc_in       = 8'h00;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'(0));
        checkOutput("rst_instr", 32'(instr), 32'(0));
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'(0));
        checkOutput("rst_mem_en", 32'(mem_en), 32'(0));
        reset_n = 1'b1;
        #1;
        checkOutput("rst_pc_ready", 32'(pc_ready), 32'(1));

        $display("[TB] streaming addresses 0..3");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] backpressure with 10,11,12");
        applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd11, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 8'd12, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd12, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] flush with buffered and in-flight work");
        applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd21, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] flush coinciding with pop and pc_valid");
        applyStimulus(1'b1, 8'd30, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd31, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd32, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd33, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 8'd60, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd61, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd62, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_instr_valid", 32'(instr_valid), 32'(0));
        checkOutput("arst_mem_en", 32'(mem_en), 32'(0));
        checkOutput("arst_instr", 32'(instr), 32'(0));
        checkOutput("arst_instr_pc", 32'(instr_pc), 32'(0));
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        pc_valid = 1'b0;
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] random handshake traffic");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
